// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// The legal-mask table is only consulted when DMEM_FAULT_EN is defined.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic       WE_WRITE  = 1'b1;
    localparam logic       WE_READ   = 1'b0;
    localparam logic [3:0] MASK_WORD = 4'b1111;

    localparam int N_LEGAL_MASKS = 7;
    localparam logic [3:0] LEGAL_MASKS [N_LEGAL_MASKS] = '{
        4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, MASK_WORD
    };

    function automatic logic is_legal_mask(input logic [3:0] m);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < N_LEGAL_MASKS; i++) begin
            if (m == LEGAL_MASKS[i]) ok = 1'b1;
        end
        return ok;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Core-side data-memory request/response bundle.
// With DMEM_FAULT_EN defined the bundle also carries the fault flag.
interface dmem_responder_if;

    logic        request;
    logic        we_re;
    logic [3:0]  mask;
    logic [31:0] address;
    logic [31:0] store_data;
    logic [31:0] load_data;
    logic        valid;
    logic        busy;
`ifdef DMEM_FAULT_EN
    logic        fault;

    modport master (
        output request, we_re, mask, address, store_data,
        input  load_data, valid, busy, fault
    );

    modport slave (
        input  request, we_re, mask, address, store_data,
        output load_data, valid, busy, fault
    );
`else
    modport master (
        output request, we_re, mask, address, store_data,
        input  load_data, valid, busy
    );

    modport slave (
        input  request, we_re, mask, address, store_data,
        output load_data, valid, busy
    );
`endif

endinterface

// File: rtl/dmem_byte_array.sv
// Word-organised storage with per-byte write enables.
// Synchronous write, combinational read; contents are never reset.
module dmem_byte_array #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [3:0]            be,
    input  logic [ADDR_WIDTH-1:0] idx,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: byte-masked word storage with a programmable response latency.
// Optional DMEM_FAULT_EN adds a fault flag for out-of-range addresses and illegal write masks.
//
// state | meaning
// IDLE  | no transaction outstanding, accepting requests
// WAIT  | transaction latched, counting down to its commit edge
// RESP  | valid pulse cycle; a new request is accepted without a bubble
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 1
) (
    input  logic           clk,
    input  logic           rst,
    dmem_responder_if.slave bus
);

    localparam bit DIRECT = (LATENCY == 1);

    state_e                state_q;
    logic [3:0]            cnt_q;
    logic                  we_q;
    logic [3:0]            mask_q;
    logic [ADDR_WIDTH-1:0] idx_q;
    logic [31:0]           wdata_q;
    logic                  valid_q;
    logic                  busy_q;
    logic [31:0]           load_q;

    logic                  accept;
    logic                  commit;
    logic                  drop;
    logic                  mem_we;
    logic                  sel_we;
    logic [3:0]            sel_mask;
    logic [ADDR_WIDTH-1:0] sel_idx;
    logic [ADDR_WIDTH-1:0] req_idx;
    logic [31:0]           sel_wdata;
    logic [31:0]           rdata;
    logic                  unused_addr;

    assign req_idx = bus.address[ADDR_WIDTH+1:2];
    assign accept  = bus.request && (state_q != WAIT);

    // With a one-cycle latency the commit edge is the accept edge, so the live request is used.
    assign commit    = rst && (DIRECT ? accept : (state_q == WAIT && cnt_q == '0));
    assign sel_we    = DIRECT ? bus.we_re      : we_q;
    assign sel_mask  = DIRECT ? bus.mask       : mask_q;
    assign sel_idx   = DIRECT ? req_idx        : idx_q;
    assign sel_wdata = DIRECT ? bus.store_data : wdata_q;

`ifdef DMEM_FAULT_EN
    logic hi_q;
    logic fault_q;
    logic req_hi;
    logic sel_hi;

    assign req_hi      = |bus.address[31:ADDR_WIDTH+2];
    assign sel_hi      = DIRECT ? req_hi : hi_q;
    assign drop        = sel_hi || (sel_we == WE_WRITE && !is_legal_mask(sel_mask));
    assign bus.fault   = fault_q;
    assign unused_addr = ^bus.address[1:0];
`else
    assign drop        = 1'b0;
    assign unused_addr = ^{bus.address[31:ADDR_WIDTH+2], bus.address[1:0]};
`endif

    assign mem_we = commit && (sel_we == WE_WRITE) && !drop;

    dmem_byte_array #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_array (
        .clk  (clk),
        .we   (mem_we),
        .be   (sel_mask),
        .idx  (sel_idx),
        .wdata(sel_wdata),
        .rdata(rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            load_q  <= '0;
`ifdef DMEM_FAULT_EN
            fault_q <= 1'b0;
`endif
        end else begin
            valid_q <= commit;
`ifdef DMEM_FAULT_EN
            fault_q <= commit && drop;
`endif
            if (commit && sel_we == WE_READ) load_q <= drop ? '0 : rdata;

            unique case (state_q)
                IDLE, RESP: begin
                    if (bus.request) begin
                        we_q    <= bus.we_re;
                        mask_q  <= bus.mask;
                        idx_q   <= req_idx;
                        wdata_q <= bus.store_data;
`ifdef DMEM_FAULT_EN
                        hi_q    <= req_hi;
`endif
                        busy_q  <= 1'b1;
                        if (DIRECT) begin
                            state_q <= RESP;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= 4'(LATENCY - 2);
                        end
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                WAIT: begin
                    if (cnt_q == '0) state_q <= RESP;
                    else             cnt_q   <= cnt_q - 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.load_data = load_q;
    assign bus.valid     = valid_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (latency 1, 3, 4) share one random stimulus
// stream and are compared each cycle against a timestamp-based transaction model.
module tb_dmem_responder;

    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;
    localparam int NDUT  = 3;
    localparam int LAT [NDUT] = '{1, 3, 4};
    localparam int NPOOL = 10;
    localparam int POOL [NPOOL] = '{0, 1, 2, 3, 16, 32, 100, 511, 1022, 1023};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req;
    logic        we;
    logic [3:0]  msk;
    logic [31:0] adr;
    logic [31:0] sdat;

    dmem_responder_if bus1 ();
    dmem_responder_if bus3 ();
    dmem_responder_if bus4 ();

    assign bus1.request = req;  assign bus1.we_re = we;  assign bus1.mask = msk;
    assign bus1.address = adr;  assign bus1.store_data = sdat;
    assign bus3.request = req;  assign bus3.we_re = we;  assign bus3.mask = msk;
    assign bus3.address = adr;  assign bus3.store_data = sdat;
    assign bus4.request = req;  assign bus4.we_re = we;  assign bus4.mask = msk;
    assign bus4.address = adr;  assign bus4.store_data = sdat;

    dmem_responder #(.ADDR_WIDTH(AW), .LATENCY(1)) u_l1 (.clk(clk), .rst(rst), .bus(bus1));
    dmem_responder #(.ADDR_WIDTH(AW), .LATENCY(3)) u_l3 (.clk(clk), .rst(rst), .bus(bus3));
    dmem_responder #(.ADDR_WIDTH(AW), .LATENCY(4)) u_l4 (.clk(clk), .rst(rst), .bus(bus4));

    logic [31:0] got_load  [NDUT];
    logic        got_valid [NDUT];
    logic        got_busy  [NDUT];
    assign got_load[0] = bus1.load_data;  assign got_valid[0] = bus1.valid;  assign got_busy[0] = bus1.busy;
    assign got_load[1] = bus3.load_data;  assign got_valid[1] = bus3.valid;  assign got_busy[1] = bus3.busy;
    assign got_load[2] = bus4.load_data;  assign got_valid[2] = bus4.valid;  assign got_busy[2] = bus4.busy;
`ifdef DMEM_FAULT_EN
    logic got_fault [NDUT];
    assign got_fault[0] = bus1.fault;
    assign got_fault[1] = bus3.fault;
    assign got_fault[2] = bus4.fault;
`endif

    // Reference model: one pending transaction per instance, tagged with its accept and commit edge.
    logic [31:0] mem_m [NDUT][DEPTH];
    bit          t_live  [NDUT];
    bit          t_we    [NDUT];
    logic [3:0]  t_mask  [NDUT];
    int          t_idx   [NDUT];
    logic [31:0] t_data  [NDUT];
    bit          t_hi    [NDUT];
    int          t_commit[NDUT];
    int          next_ok [NDUT];
    bit          e_valid [NDUT];
    bit          e_busy  [NDUT];
    bit          e_fault [NDUT];
    logic [31:0] e_load  [NDUT];
    int          edge_n;

    int n_checks;
    int n_fail;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_fault(input bit w, input logic [3:0] m, input bit hi);
`ifdef DMEM_FAULT_EN
        return hi || (w && !(m inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111}));
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_edge();
        bit bad;
        for (int d = 0; d < NDUT; d++) begin
            if (!rst) begin
                t_live[d]  = 1'b0;
                e_valid[d] = 1'b0;
                e_busy[d]  = 1'b0;
                e_fault[d] = 1'b0;
                e_load[d]  = '0;
                next_ok[d] = edge_n + 1;
            end else begin
                if (req && edge_n >= next_ok[d]) begin
                    t_live[d]   = 1'b1;
                    t_we[d]     = we;
                    t_mask[d]   = msk;
                    t_idx[d]    = int'((adr >> 2) % DEPTH);
                    t_data[d]   = sdat;
                    t_hi[d]     = (adr >> (AW + 2)) != 0;
                    t_commit[d] = edge_n + LAT[d] - 1;
                    next_ok[d]  = edge_n + LAT[d];
                end
                e_valid[d] = 1'b0;
                e_fault[d] = 1'b0;
                if (t_live[d] && t_commit[d] == edge_n) begin
                    bad = is_fault(t_we[d], t_mask[d], t_hi[d]);
                    e_valid[d] = 1'b1;
                    e_fault[d] = bad;
                    if (t_we[d]) begin
                        if (!bad) begin
                            for (int b = 0; b < 4; b++)
                                if (t_mask[d][b]) mem_m[d][t_idx[d]][8*b +: 8] = t_data[d][8*b +: 8];
                        end
                    end else begin
                        e_load[d] = bad ? 32'h0 : mem_m[d][t_idx[d]];
                    end
                end
                e_busy[d] = t_live[d] && edge_n <= t_commit[d];
            end
        end
        edge_n++;
    endtask

    task automatic check_outputs();
        for (int d = 0; d < NDUT; d++) begin
            check_eq($sformatf("valid_l%0d", LAT[d]), 32'(got_valid[d]), 32'(e_valid[d]));
            check_eq($sformatf("busy_l%0d", LAT[d]),  32'(got_busy[d]),  32'(e_busy[d]));
            check_eq($sformatf("load_l%0d", LAT[d]),  got_load[d],       e_load[d]);
`ifdef DMEM_FAULT_EN
            check_eq($sformatf("fault_l%0d", LAT[d]), 32'(got_fault[d]), 32'(e_fault[d]));
`endif
        end
    endtask

    task automatic step(input bit r, input bit rq, input bit w, input logic [3:0] m,
                        input logic [31:0] a, input logic [31:0] dat);
        rst = r; req = rq; we = w; msk = m; adr = a; sdat = dat;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic check_all_loads(input string tag, input logic [31:0] exp);
        for (int d = 0; d < NDUT; d++)
            check_eq($sformatf("%s_l%0d", tag, LAT[d]), got_load[d], exp);
    endtask

    initial begin
        logic [3:0] vseq;
        logic [3:0] bseq;
        logic [31:0] a;
        n_checks = 0;
        n_fail   = 0;
        edge_n   = 0;
        for (int d = 0; d < NDUT; d++) begin
            t_live[d]  = 1'b0;
            next_ok[d] = 0;
        end

        // Reset held with a pending write request
        step(1'b0, 1'b1, 1'b1, 4'hF, 32'h40, 32'h1111_1111);
        step(1'b0, 1'b1, 1'b1, 4'hF, 32'h40, 32'h1111_1111);

        for (int p = 0; p < NPOOL; p++) begin
            step(1'b1, 1'b1, 1'b1, 4'hF, 32'(POOL[p]) << 2, 32'hA5A5_0000 | 32'(POOL[p]));
            idle(4);
        end

        // Word store then back-to-back read
        step(1'b1, 1'b1, 1'b1, 4'hF, 32'h40, 32'hDEAD_BEEF);
        step(1'b1, 1'b1, 1'b0, 4'hF, 32'h40, 32'h0);
        check_eq("b2b_read_l1", got_load[0], 32'hDEAD_BEEF);
        idle(4);
        step(1'b1, 1'b1, 1'b0, 4'hF, 32'h40, 32'h0);
        idle(4);
        check_all_loads("word_store", 32'hDEAD_BEEF);

        // Byte store, then an empty-mask write
        step(1'b1, 1'b1, 1'b1, 4'b0001, 32'h40, 32'h0000_00AA);
        idle(4);
        step(1'b1, 1'b1, 1'b0, 4'b0001, 32'h41, 32'h0);
        idle(4);
        check_all_loads("byte_store", 32'hDEAD_BEAA);
        step(1'b1, 1'b1, 1'b1, 4'b0000, 32'h40, 32'h5555_5555);
        idle(4);
        step(1'b1, 1'b1, 1'b0, 4'b0000, 32'h40, 32'h0);
        idle(4);
        check_all_loads("mask0_write", 32'hDEAD_BEAA);

        // Latency-3 timing, with a request during WAIT that must be ignored
        step(1'b1, 1'b1, 1'b0, 4'hF, 32'h40, 32'h0);
        vseq[0] = got_valid[1]; bseq[0] = got_busy[1];
        step(1'b1, 1'b1, 1'b0, 4'hF, 32'h0, 32'h0);
        vseq[1] = got_valid[1]; bseq[1] = got_busy[1];
        idle(1);
        vseq[2] = got_valid[1]; bseq[2] = got_busy[1];
        idle(1);
        vseq[3] = got_valid[1]; bseq[3] = got_busy[1];
        check_eq("lat3_valid_seq", 32'(vseq), 32'h4);
        check_eq("lat3_busy_seq",  32'(bseq), 32'h7);
        check_eq("lat3_load", got_load[1], 32'hDEAD_BEAA);
        idle(4);

        // Reset while a latency-4 write is waiting
        step(1'b1, 1'b1, 1'b1, 4'hF, 32'h80, 32'h1234_5678);
        idle(1);
        step(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        idle(4);
        step(1'b1, 1'b1, 1'b0, 4'hF, 32'h80, 32'h0);
        idle(4);
        check_eq("rst_abort_l1", got_load[0], 32'h1234_5678);
        check_eq("rst_abort_l3", got_load[1], 32'hA5A5_0020);
        check_eq("rst_abort_l4", got_load[2], 32'hA5A5_0020);

`ifdef DMEM_FAULT_EN
        step(1'b1, 1'b1, 1'b0, 4'hF, 32'h0010_0000, 32'h0);
        check_eq("oor_fault_l1", 32'(got_fault[0]), 32'h1);
        check_eq("oor_valid_l1", 32'(got_valid[0]), 32'h1);
        idle(4);
        check_all_loads("oor_load", 32'h0);
        step(1'b1, 1'b1, 1'b1, 4'b0110, 32'h40, 32'hFFFF_FFFF);
        idle(4);
        step(1'b1, 1'b1, 1'b0, 4'hF, 32'h40, 32'h0);
        idle(4);
        check_all_loads("bad_mask", 32'hDEAD_BEAA);
`endif

        for (int i = 0; i < 600; i++) begin
            a = (32'(POOL[$urandom_range(0, NPOOL - 1)]) << 2) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) a = a | (32'($urandom_range(1, 4095)) << 12);
            step($urandom_range(0, 49) != 0, $urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 15)), a, $urandom);
        end
        idle(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
